// File: rtl/pc_gen_pkg.sv
// ============================================================================
// Module      : pc_gen_pkg
// Description : Shared encodings and default addresses for the fetch-stage
//               program-counter generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_gen_pkg;

    // Redirect kind of the ID-stage instruction
    localparam logic [2:0] NPC_SEQ  = 3'b000;
    localparam logic [2:0] NPC_BR   = 3'b001;
    localparam logic [2:0] NPC_J    = 3'b010;
    localparam logic [2:0] NPC_JR   = 3'b011;
    localparam logic [2:0] NPC_ERET = 3'b100;

    // Conditional branch forms
    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LEZ = 3'b010;
    localparam logic [2:0] BR_GTZ = 3'b011;
    localparam logic [2:0] BR_LTZ = 3'b100;
    localparam logic [2:0] BR_GEZ = 3'b101;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h0000_4180;

endpackage : pc_gen_pkg

`default_nettype wire

// File: rtl/br_cmp.sv
// ============================================================================
// Module      : br_cmp
// Description : Combinational signed branch-condition evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_cmp
    import pc_gen_pkg::*;
(
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [2:0]  br_cond,
    output logic        taken
);

    logic w_eq;
    logic w_neg;
    logic w_zero;

    assign w_eq   = (rs == rt);
    assign w_neg  = rs[31];
    assign w_zero = (rs == 32'h0000_0000);

    always_comb begin
        taken = 1'b0;
        case (br_cond)
            BR_EQ:   taken = w_eq;
            BR_NE:   taken = !w_eq;
            BR_LEZ:  taken = w_neg || w_zero;
            BR_GTZ:  taken = !w_neg && !w_zero;
            BR_LTZ:  taken = w_neg;
            BR_GEZ:  taken = !w_neg;
            default: taken = 1'b0;
        endcase
    end

endmodule : br_cmp

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// Module      : pc_gen
// Description : IF-stage PC register with branch/jump/exception/ERET
//               redirect resolution and EPC capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  npc_sel,
    input  logic [2:0]  br_cond,
    input  logic [31:0] pc_id,
    input  logic [25:0] imm,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic        boj,
    output logic        adel_if
);

    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic [31:0] w_id_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_target;
    logic        w_taken;
    logic        w_redirect;

    br_cmp u_br_cmp (
        .rs      (rs),
        .rt      (rt),
        .br_cond (br_cond),
        .taken   (w_taken)
    );

    // J keeps the region bits of the delay-slot address, not of pc_id
    assign w_id_plus4  = pc_id + 32'd4;
    assign w_br_target = w_id_plus4 + {{14{imm[15]}}, imm[15:0], 2'b00};
    assign w_j_target  = {w_id_plus4[31:28], imm, 2'b00};

    always_comb begin
        w_redirect = 1'b0;
        w_target   = w_id_plus4;
        case (npc_sel)
            NPC_BR: begin
                w_redirect = w_taken;
                w_target   = w_br_target;
            end
            NPC_J: begin
                w_redirect = 1'b1;
                w_target   = w_j_target;
            end
            NPC_JR: begin
                w_redirect = 1'b1;
                w_target   = rs;
            end
            NPC_ERET: begin
                w_redirect = 1'b1;
                w_target   = r_epc;
            end
            default: begin
                w_redirect = 1'b0;
                w_target   = w_id_plus4;
            end
        endcase
    end

    assign boj = w_redirect && !stall && !exc_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (exc_req) begin
            r_pc <= EXC_VEC;
        end else if (stall) begin
            r_pc <= r_pc;
        end else if (boj) begin
            r_pc <= w_target;
        end else begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // A faulting delay-slot instruction restarts at its branch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_epc <= RESET_PC;
        end else if (exc_req) begin
            r_epc <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
        end
    end

    assign pc      = r_pc;
    assign epc     = r_epc;
    assign adel_if = |r_pc[1:0];

endmodule : pc_gen

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// Module      : tb_pc_gen
// Description : Self-checking bench for pc_gen using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [2:0]  npc_sel;
    logic [2:0]  br_cond;
    logic [31:0] pc_id;
    logic [25:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exc_req;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        boj;
    logic        adel_if;

    int n_checks = 0;
    int n_fail   = 0;

    pc_gen u_dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .npc_sel (npc_sel),
        .br_cond (br_cond),
        .pc_id   (pc_id),
        .imm     (imm),
        .rs      (rs),
        .rt      (rt),
        .exc_req (exc_req),
        .exc_pc  (exc_pc),
        .exc_bd  (exc_bd),
        .pc      (pc),
        .epc     (epc),
        .boj     (boj),
        .adel_if (adel_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  sel;
        logic [2:0]  cond;
        logic [31:0] id;
        logic [25:0] im;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp_boj;
        logic [31:0] exp_tgt;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall   = 1'b0;
        npc_sel = 3'b000;
        br_cond = 3'b000;
        pc_id   = 32'h0;
        imm     = 26'h0;
        rs      = 32'h0;
        rt      = 32'h0;
        exc_req = 1'b0;
        exc_pc  = 32'h0;
        exc_bd  = 1'b0;
    endtask

    logic [31:0] exp_pc;

    initial begin
        //            sel     cond    pc_id          imm          rs             rt        boj  target
        vecs[0]  = '{3'b001, 3'b000, 32'h0000_3008, 26'h000FFFE, 32'd5,         32'd6,     1'b0, 32'h0};
        vecs[1]  = '{3'b001, 3'b000, 32'h0000_3008, 26'h000FFFE, 32'd5,         32'd5,     1'b1, 32'h0000_3004};
        vecs[2]  = '{3'b001, 3'b100, 32'h0000_3000, 26'h0000010, 32'h8000_0000, 32'h0,     1'b1, 32'h0000_3044};
        vecs[3]  = '{3'b001, 3'b011, 32'h0000_3000, 26'h0000010, 32'h0,         32'h0,     1'b0, 32'h0};
        vecs[4]  = '{3'b001, 3'b101, 32'h0000_3100, 26'h0000004, 32'h0,         32'h5,     1'b1, 32'h0000_3114};
        vecs[5]  = '{3'b001, 3'b001, 32'h0000_3200, 26'h0000000, 32'd1,         32'd2,     1'b1, 32'h0000_3204};
        vecs[6]  = '{3'b001, 3'b010, 32'h0000_3000, 26'h0000001, 32'hFFFF_FFFF, 32'h0,     1'b1, 32'h0000_3008};
        vecs[7]  = '{3'b001, 3'b011, 32'h0000_3000, 26'h0000002, 32'h7FFF_FFFF, 32'h0,     1'b1, 32'h0000_300C};
        vecs[8]  = '{3'b001, 3'b110, 32'h0000_3000, 26'h0000002, 32'hFFFF_FFFF, 32'h0,     1'b0, 32'h0};
        vecs[9]  = '{3'b010, 3'b000, 32'h0FFF_FFFC, 26'h0000100, 32'h0,         32'h0,     1'b1, 32'h1000_0400};
        vecs[10] = '{3'b011, 3'b000, 32'h0000_3000, 26'h0000000, 32'h0000_2000, 32'h0,     1'b1, 32'h0000_2000};
        vecs[11] = '{3'b101, 3'b000, 32'h0000_3000, 26'h0000000, 32'h0000_5000, 32'h0,     1'b0, 32'h0};
        vecs[12] = '{3'b001, 3'b101, 32'h0000_3000, 26'h0000008, 32'hFFFF_FFFF, 32'h0,     1'b0, 32'h0};
        vecs[13] = '{3'b001, 3'b100, 32'h0000_3000, 26'h0000008, 32'h0,         32'h0,     1'b0, 32'h0};

        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        chk("reset_pc", pc, 32'h0000_3000);
        chk("reset_epc", epc, 32'h0000_3000);
        chk("reset_adel", {31'b0, adel_if}, 32'h0);
        reset = 1'b0;

        exp_pc = 32'h0000_3000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_pc = exp_pc + 32'd4;
            chk("free_run_pc", pc, exp_pc);
        end
        chk("free_run_epc", epc, 32'h0000_3000);

        for (int i = 0; i < NVEC; i++) begin
            npc_sel = vecs[i].sel;
            br_cond = vecs[i].cond;
            pc_id   = vecs[i].id;
            imm     = vecs[i].im;
            rs      = vecs[i].a;
            rt      = vecs[i].b;
            #1;
            chk($sformatf("vec%0d_boj", i), {31'b0, boj}, {31'b0, vecs[i].exp_boj});
            exp_pc = vecs[i].exp_boj ? vecs[i].exp_tgt : exp_pc + 32'd4;
            @(negedge clk);
            chk($sformatf("vec%0d_pc", i), pc, exp_pc);
            chk($sformatf("vec%0d_adel", i), {31'b0, adel_if}, 32'h0);
        end

        // JR held by a two-cycle stall, then released into a misaligned target
        npc_sel = 3'b011;
        rs      = 32'h0000_3102;
        stall   = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("stall_boj", {31'b0, boj}, 32'h0);
            @(negedge clk);
            chk("stall_hold_pc", pc, exp_pc);
        end
        stall = 1'b0;
        #1;
        chk("jr_release_boj", {31'b0, boj}, 32'h1);
        @(negedge clk);
        chk("jr_pc", pc, 32'h0000_3102);
        chk("jr_adel", {31'b0, adel_if}, 32'h1);

        // Exception in a delay slot beats a concurrent J
        npc_sel = 3'b010;
        pc_id   = 32'h0000_3100;
        imm     = 26'h0000800;
        exc_req = 1'b1;
        exc_pc  = 32'h0000_3010;
        exc_bd  = 1'b1;
        #1;
        chk("exc_boj", {31'b0, boj}, 32'h0);
        @(negedge clk);
        chk("exc_pc", pc, 32'h0000_4180);
        chk("exc_epc", epc, 32'h0000_300C);
        chk("exc_adel", {31'b0, adel_if}, 32'h0);

        exc_req = 1'b0;
        exc_bd  = 1'b0;
        npc_sel = 3'b100;
        #1;
        chk("eret_boj", {31'b0, boj}, 32'h1);
        @(negedge clk);
        chk("eret_pc", pc, 32'h0000_300C);
        chk("eret_epc_kept", epc, 32'h0000_300C);

        // Exception wins over stall; epc captured without delay-slot fix
        npc_sel = 3'b000;
        stall   = 1'b1;
        exc_req = 1'b1;
        exc_pc  = 32'h0000_3020;
        @(negedge clk);
        chk("exc_stall_pc", pc, 32'h0000_4180);
        chk("exc_stall_epc", epc, 32'h0000_3020);
        exc_req = 1'b0;
        @(negedge clk);
        chk("stall_after_exc_pc", pc, 32'h0000_4180);
        chk("stall_epc_hold", epc, 32'h0000_3020);
        stall = 1'b0;
        @(negedge clk);
        chk("resume_pc", pc, 32'h0000_4184);

        // Reset beats a simultaneous exception
        reset   = 1'b1;
        exc_req = 1'b1;
        exc_pc  = 32'h0000_5000;
        @(negedge clk);
        chk("rst_exc_pc", pc, 32'h0000_3000);
        chk("rst_exc_epc", epc, 32'h0000_3000);
        reset   = 1'b0;
        exc_req = 1'b0;
        @(negedge clk);
        chk("post_reset_pc", pc, 32'h0000_3004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_gen

`default_nettype wire
